matmul_output_writer: RTL
=========================

MATMUL_OUTPUT_WRITER -- requirements
Module: matmul_output_writer

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning bits per C element.
REQ-002 SHALL have parameter BB_MAT_MUL_SIZE, default 8, meaning elements per C row word.
REQ-003 SHALL have parameter AWIDTH, default 10, meaning C RAM address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two), meaning entries per input FIFO.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse: clear counters/flags, begin new job.
REQ-008 expected_writes  in  8  total C rows to write this job; sampled on start.
REQ-009 c_data_0 / c_data_1  in  BB_MAT_MUL_SIZE*DWIDTH  C row words from tiles 0_1 and 1_1.
REQ-010 c_addr_0 / c_addr_1  in  AWIDTH  C RAM address for the matching word.
REQ-011 c_valid_0 / c_valid_1  in  1  word/address valid this cycle; no backpressure to source.
REQ-012 c_wr_data  out  BB_MAT_MUL_SIZE*DWIDTH  RAM write data, registered.
REQ-013 c_wr_addr  out  AWIDTH  RAM write address, registered.
REQ-014 c_wr_en  out  1  RAM write strobe, registered.
REQ-015 c_wr_ready  in  1  RAM accepts write when high; write completes when c_wr_en && c_wr_ready.
REQ-016 done  out  1  level; high once expected_writes writes complete, until next start.
REQ-017 overflow  out  1  sticky: a valid word was dropped.

Function
REQ-018 Each input SHALL have a FIFO_DEPTH-entry FIFO of {addr, data}, with wrapping pointers and an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-019 Push on c_valid_i SHALL be accepted when FIFO not full, or when full and the same FIFO pops that cycle.
REQ-020 c_valid_i with FIFO full and no same-cycle pop SHALL drop the word and set overflow; no other state changes.
REQ-021 Output register SHALL load when empty or its write completes (c_wr_en && c_wr_ready); otherwise hold data, addr, and c_wr_en=1 stable.
REQ-022 On load with exactly one FIFO non-empty, SHALL pop that FIFO.
REQ-023 On load with both non-empty, SHALL pop the FIFO not served last (round-robin); after reset/start, priority goes to FIFO 0.
REQ-024 On load with both empty, c_wr_en SHALL go 0.
REQ-025 Minimum latency: word presented at cycle N into an empty FIFO with idle output SHALL appear on c_wr_* at cycle N+2 (push at edge N, pop/load at edge N+1).
REQ-026 Write counter (8 bits) SHALL increment on each completed write; done SHALL assert the cycle after the counter reaches expected_writes; further writes SHALL still drain but not wrap the counter past 255.
REQ-027 expected_writes=0 SHALL give done=1 the cycle after start.
REQ-028 start SHALL flush both FIFOs, clear c_wr_en, counter, done, overflow, round-robin pointer; c_valid_i in the start cycle SHALL be ignored.

Reset
REQ-029 While reset is high, c_wr_en=0, c_wr_data=0, c_wr_addr=0, done=0, overflow=0, FIFOs empty, counter=0, expected_writes register=0.
REQ-030 Reset asserted mid-job SHALL discard all buffered words immediately, without waiting for a clock edge.

Verification
REQ-031 Single word: start, expected_writes=1; c_valid_0 with addr 0x010, data 0x0102..08; c_wr_ready=1 -> c_wr_en=1 two cycles later with those values; done=1 the following cycle.
REQ-032 Simultaneous: c_valid_0 and c_valid_1 together for 4 cycles, addrs 0x00-0x03 and 0x08-0x0B, c_wr_ready=1 -> 8 writes alternating 0x00,0x08,0x01,0x09,...; overflow stays 0.
REQ-033 Backpressure: c_wr_ready=0 for 10 cycles while 6 words arrive on input 0 (FIFO_DEPTH=4) -> output holds the first word stable; overflow=1 after the 6th word; 5 words are written once ready is asserted.
REQ-034 Full plus pop: FIFO 0 full, c_wr_ready=1, new c_valid_0 in a pop cycle -> word accepted and overflow=0.
REQ-035 Reset mid-job: assert reset asynchronously with 3 words buffered -> c_wr_en=0 at once; no writes after release until new valid input arrives.
REQ-036 Restart: start pulse with buffered words and overflow=1 -> all buffered words discarded, overflow=0, done=0, counter=0.

Source files
------------

// File: rtl/matmul_output_writer.sv
`default_nettype none
// ============================================================================
// matmul_output_writer: merges C row words from two tiles through small FIFOs
// into one registered RAM write port. Revision: 1.0
// ============================================================================
module matmul_output_writer #(
  parameter int DWIDTH          = 8,
  parameter int BB_MAT_MUL_SIZE = 8,
  parameter int AWIDTH          = 10,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [7:0]                        expected_writes,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_0,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_1,
  input  logic [AWIDTH-1:0]                 c_addr_0,
  input  logic [AWIDTH-1:0]                 c_addr_1,
  input  logic                              c_valid_0,
  input  logic                              c_valid_1,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_wr_data,
  output logic [AWIDTH-1:0]                 c_wr_addr,
  output logic                              c_wr_en,
  input  logic                              c_wr_ready,
  output logic                              done,
  output logic                              overflow
);

  localparam int WW = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int EW = AWIDTH + WW;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] C_FULL = (PW + 1)'(FIFO_DEPTH);

  logic [EW-1:0] mem_q [2][FIFO_DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] wptr_d [2];
  logic [PW-1:0] rptr_q [2];
  logic [PW-1:0] rptr_d [2];
  logic [PW:0]   cnt_q  [2];
  logic [PW:0]   cnt_d  [2];
  logic [EW-1:0] din    [2];

  logic [1:0]    valid;
  logic [1:0]    nonempty;
  logic [1:0]    pop;
  logic [1:0]    push;
  logic [1:0]    drop;
  logic          load;
  logic          complete;

  logic          en_q, en_d;
  logic [WW-1:0] data_q, data_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic          rr_q, rr_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [7:0]    exp_q, exp_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  assign din[0] = {c_addr_0, c_data_0};
  assign din[1] = {c_addr_1, c_data_1};
  assign valid  = {c_valid_1, c_valid_0};

  assign load     = !en_q || c_wr_ready;
  assign complete = en_q && c_wr_ready;

  always_comb begin
    nonempty = 2'b00;
    pop      = 2'b00;
    push     = 2'b00;
    drop     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
    end
    // rr_q names the FIFO that wins when both hold data
    if (load && !start) begin
      if (nonempty == 2'b11) begin
        pop = rr_q ? 2'b10 : 2'b01;
      end else begin
        pop = nonempty;
      end
    end
    for (int i = 0; i < 2; i++) begin
      push[i] = valid[i] && !start && ((cnt_q[i] != C_FULL) || pop[i]);
      drop[i] = valid[i] && !start && (cnt_q[i] == C_FULL) && !pop[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wptr_d[i] = wptr_q[i] + PW'(push[i]);
      rptr_d[i] = rptr_q[i] + PW'(pop[i]);
      cnt_d[i]  = cnt_q[i] + (PW + 1)'(push[i]) - (PW + 1)'(pop[i]);
      if (start) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
      end
    end

    en_d   = en_q;
    data_d = data_q;
    addr_d = addr_q;
    rr_d   = rr_q;
    if (start) begin
      en_d = 1'b0;
      rr_d = 1'b0;
    end else if (load) begin
      if (pop[0]) begin
        {addr_d, data_d} = mem_q[0][rptr_q[0]];
        en_d = 1'b1;
        rr_d = 1'b1;
      end else if (pop[1]) begin
        {addr_d, data_d} = mem_q[1][rptr_q[1]];
        en_d = 1'b1;
        rr_d = 1'b0;
      end else begin
        en_d = 1'b0;
      end
    end

    // counter saturates so late drains never wrap it
    wcnt_d = wcnt_q;
    if (start) begin
      wcnt_d = 8'd0;
    end else if (complete && (wcnt_q != 8'hFF)) begin
      wcnt_d = wcnt_q + 8'd1;
    end

    exp_d   = start ? expected_writes : exp_q;
    armed_d = armed_q || start;
    if (start) begin
      done_d = (expected_writes == 8'd0);
    end else begin
      done_d = done_q || (armed_q && (wcnt_d >= exp_q));
    end
    ovf_d = start ? 1'b0 : (ovf_q || (drop != 2'b00));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= din[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      en_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      rr_q    <= 1'b0;
      wcnt_q  <= 8'd0;
      exp_q   <= 8'd0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      en_q    <= en_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rr_q    <= rr_d;
      wcnt_q  <= wcnt_d;
      exp_q   <= exp_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign c_wr_en   = en_q;
  assign c_wr_data = data_q;
  assign c_wr_addr = addr_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire
